// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges fixed-latency ALU results and FIFO-buffered load results onto one register-file write port.
// Optional macro WB_LD_BYPASS_EN lets a load skip the empty FIFO when the ALU is idle.
module wb_arbiter #(
    parameter int LD_FIFO_DEPTH = 4,
    parameter int MAX_WAIT      = 3
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_alu_valid,
    input  logic [4:0]                       i_alu_rd,
    input  logic [31:0]                      i_alu_data,
    output logic                             o_alu_ready,
    input  logic                             i_ld_valid,
    input  logic [4:0]                       i_ld_rd,
    input  logic [31:0]                      i_ld_data,
    output logic                             o_ld_ready,
    output logic [$clog2(LD_FIFO_DEPTH):0]   o_ld_count,
    output logic                             o_reg_write,
    output logic [4:0]                       o_write_rd,
    output logic [31:0]                      o_write_data
);

    localparam int PTR_W  = $clog2(LD_FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [4:0]        fifo_rd_mem   [LD_FIFO_DEPTH];
    logic [31:0]       fifo_data_mem [LD_FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;

    logic              write_reg, write_next;
    logic [4:0]        write_rd_reg, write_rd_next;
    logic [31:0]       write_data_reg, write_data_next;

    logic              fifo_empty;
    logic              force_head;
    logic              ld_ready;
    logic              ld_accept;
    logic              ld_bypass;
    logic              push;
    logic              pop;
    logic              grant_head;
    logic              grant_alu;
    logic [4:0]        head_rd;
    logic [31:0]       head_data;

    assign head_rd   = fifo_rd_mem[rd_ptr_reg];
    assign head_data = fifo_data_mem[rd_ptr_reg];

    always_comb begin
        fifo_empty = (count_reg == '0);
        force_head = !fifo_empty && (wait_cnt_reg == WAIT_W'(MAX_WAIT));
        // Readiness comes from the registered count only, so a full FIFO never pops through.
        ld_ready   = (count_reg < CNT_W'(LD_FIFO_DEPTH));
        ld_accept  = i_ld_valid && ld_ready;
`ifdef WB_LD_BYPASS_EN
        ld_bypass  = ld_accept && fifo_empty && !i_alu_valid;
`else
        ld_bypass  = 1'b0;
`endif
        // rd==0 loads are accepted but never stored.
        push       = ld_accept && (i_ld_rd != 5'd0) && !ld_bypass;
        grant_head = force_head || (!i_alu_valid && !fifo_empty);
        grant_alu  = i_alu_valid && !force_head;
        pop        = grant_head;
    end

    always_comb begin
        wr_ptr_next   = push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
        rd_ptr_next   = pop  ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
        count_next    = count_reg + CNT_W'(push) - CNT_W'(pop);

        wait_cnt_next = wait_cnt_reg;
        if (fifo_empty || grant_head) begin
            wait_cnt_next = '0;
        end else if (wait_cnt_reg != WAIT_W'(MAX_WAIT)) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        write_next      = 1'b0;
        write_rd_next   = 5'd0;
        write_data_next = 32'd0;
        if (grant_head) begin
            if (head_rd != 5'd0) begin
                write_next      = 1'b1;
                write_rd_next   = head_rd;
                write_data_next = head_data;
            end
        end else if (grant_alu) begin
            if (i_alu_rd != 5'd0) begin
                write_next      = 1'b1;
                write_rd_next   = i_alu_rd;
                write_data_next = i_alu_data;
            end
        end else if (ld_bypass && (i_ld_rd != 5'd0)) begin
            write_next      = 1'b1;
            write_rd_next   = i_ld_rd;
            write_data_next = i_ld_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            wait_cnt_reg   <= '0;
            write_reg      <= 1'b0;
            write_rd_reg   <= 5'd0;
            write_data_reg <= 32'd0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            wait_cnt_reg   <= wait_cnt_next;
            write_reg      <= write_next;
            write_rd_reg   <= write_rd_next;
            write_data_reg <= write_data_next;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_rd_mem[wr_ptr_reg]   <= i_ld_rd;
            fifo_data_mem[wr_ptr_reg] <= i_ld_data;
        end
    end

    assign o_alu_ready  = !force_head;
    assign o_ld_ready   = ld_ready;
    assign o_ld_count   = count_reg;
    assign o_reg_write  = write_reg;
    assign o_write_rd   = write_rd_reg;
    assign o_write_data = write_data_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: ALU path, load path, starvation forcing, full FIFO, rd==0 and mid-run reset.
module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic [2:0]  ld_count;
    logic        reg_write;
    logic [4:0]  write_rd;
    logic [31:0] write_data;

    int checks = 0;
    int errors = 0;

    wb_arbiter #(.LD_FIFO_DEPTH(4), .MAX_WAIT(3)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_alu_valid  (alu_valid),
        .i_alu_rd     (alu_rd),
        .i_alu_data   (alu_data),
        .o_alu_ready  (alu_ready),
        .i_ld_valid   (ld_valid),
        .i_ld_rd      (ld_rd),
        .i_ld_data    (ld_data),
        .o_ld_ready   (ld_ready),
        .o_ld_count   (ld_count),
        .o_reg_write  (reg_write),
        .o_write_rd   (write_rd),
        .o_write_data (write_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        alu_rd    = 5'd0;
        alu_data  = 32'd0;
        ld_valid  = 1'b0;
        ld_rd     = 5'd0;
        ld_data   = 32'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write: got %b expected 0", reg_write); end
        checks++; if (write_rd !== 5'd0) begin errors++; $display("FAIL reset_write_rd: got %0d expected 0", write_rd); end
        checks++; if (write_data !== 32'd0) begin errors++; $display("FAIL reset_write_data: got %h expected 0", write_data); end
        checks++; if (ld_count !== 3'd0) begin errors++; $display("FAIL reset_ld_count: got %0d expected 0", ld_count); end
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready: got %b expected 1", ld_ready); end
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready: got %b expected 1", alu_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        $display("reset: outputs idle, count=%0d", ld_count);
    endtask

    task automatic test_alu();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        settle();
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_ready: got %b expected 1", alu_ready); end
        tick();
        idle_inputs();
        settle();
        checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL alu_reg_write: got %b expected 1", reg_write); end
        checks++; if (write_rd !== 5'd5) begin errors++; $display("FAIL alu_write_rd: got %0d expected 5", write_rd); end
        checks++; if (write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_write_data: got %h expected deadbeef", write_data); end
        tick();
        checks++; if ({reg_write, write_rd, write_data} !== 38'd0) begin errors++; $display("FAIL alu_idle: got we=%b rd=%0d data=%h expected all 0", reg_write, write_rd, write_data); end
        $display("alu: rd=5 data=deadbeef written after 1 cycle");
    endtask

    task automatic test_load();
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h1234;
        settle();
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %b expected 1", ld_ready); end
        tick();
        idle_inputs();
        settle();
`ifdef WB_LD_BYPASS_EN
        checks++; if (ld_count !== 3'd0) begin errors++; $display("FAIL load_count_bypass: got %0d expected 0", ld_count); end
        checks++; if (reg_write !== 1'b1 || write_rd !== 5'd7 || write_data !== 32'h1234) begin errors++; $display("FAIL load_write_bypass: got we=%b rd=%0d data=%h expected 1/7/1234", reg_write, write_rd, write_data); end
`else
        checks++; if (ld_count !== 3'd1) begin errors++; $display("FAIL load_count_1: got %0d expected 1", ld_count); end
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL load_early_write: got %b expected 0", reg_write); end
        tick();
        checks++; if (ld_count !== 3'd0) begin errors++; $display("FAIL load_count_0: got %0d expected 0", ld_count); end
        checks++; if (reg_write !== 1'b1 || write_rd !== 5'd7 || write_data !== 32'h1234) begin errors++; $display("FAIL load_write: got we=%b rd=%0d data=%h expected 1/7/1234", reg_write, write_rd, write_data); end
`endif
        tick();
        $display("load: rd=7 data=1234 written");
    endtask

    task automatic test_starvation();
        int alu_seq [6] = '{1, 2, 3, 4, 5, 5};
        int exp_ready [6] = '{1, 1, 1, 1, 0, 1};
        int exp_rd [7] = '{0, 1, 2, 3, 4, 9, 5};
        int stalls = 0;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) tick();
            alu_valid = (c < 6);
            alu_rd    = (c < 6) ? 5'(alu_seq[c]) : 5'd0;
            alu_data  = 32'(alu_rd) << 8;
            ld_valid  = (c == 0);
            ld_rd     = (c == 0) ? 5'd9 : 5'd0;
            ld_data   = (c == 0) ? 32'h99 : 32'd0;
            settle();
            if (c < 6) begin
                if (alu_ready === 1'b0) stalls++;
                checks++; if (alu_ready !== 1'(exp_ready[c])) begin errors++; $display("FAIL starve_alu_ready c%0d: got %b expected %0d", c, alu_ready, exp_ready[c]); end
            end
            if (c > 0) begin
                checks++; if (reg_write !== 1'b1 || write_rd !== 5'(exp_rd[c])) begin errors++; $display("FAIL starve_write c%0d: got we=%b rd=%0d expected 1/%0d", c, reg_write, write_rd, exp_rd[c]); end
            end
            if (c == 5) begin
                checks++; if (write_data !== 32'h99) begin errors++; $display("FAIL starve_load_data: got %h expected 99", write_data); end
                checks++; if (ld_count !== 3'd0) begin errors++; $display("FAIL starve_count: got %0d expected 0", ld_count); end
            end
        end
        checks++; if (stalls != 1) begin errors++; $display("FAIL starve_stall_cycles: got %0d expected 1", stalls); end
        idle_inputs();
        tick();
        $display("starvation: load forced after 3 lost cycles, alu stalled %0d cycle", stalls);
    endtask

    task automatic test_full();
        logic [4:0]  got_rd [$];
        logic [31:0] got_data [$];
        for (int c = 0; c < 12; c++) begin
            if (c > 0) tick();
            alu_valid = (c <= 5);
            alu_rd    = (c <= 5) ? 5'd20 : 5'd0;
            alu_data  = 32'hA1A1;
            ld_valid  = (c <= 5);
            ld_rd     = (c <= 4) ? 5'(11 + c) : ((c == 5) ? 5'd15 : 5'd0);
            ld_data   = 32'h1000 + 32'(ld_rd);
            settle();
            if (c == 3) begin
                checks++; if (ld_count !== 3'd3 || ld_ready !== 1'b1) begin errors++; $display("FAIL full_c3: got count=%0d ready=%b expected 3/1", ld_count, ld_ready); end
            end
            if (c == 4) begin
                checks++; if (ld_count !== 3'd4) begin errors++; $display("FAIL full_count4: got %0d expected 4", ld_count); end
                checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL full_ld_ready: got %b expected 0", ld_ready); end
                checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL full_alu_force: got %b expected 0", alu_ready); end
            end
            if (c == 5) begin
                checks++; if (ld_count !== 3'd3 || ld_ready !== 1'b1) begin errors++; $display("FAIL full_c5: got count=%0d ready=%b expected 3/1", ld_count, ld_ready); end
            end
            if (reg_write === 1'b1 && write_rd >= 5'd11 && write_rd <= 5'd15) begin
                got_rd.push_back(write_rd);
                got_data.push_back(write_data);
            end
        end
        checks++; if (got_rd.size() != 5) begin errors++; $display("FAIL full_write_count: got %0d expected 5", got_rd.size()); end
        for (int i = 0; i < 5 && i < got_rd.size(); i++) begin
            checks++; if (got_rd[i] !== 5'(11 + i) || got_data[i] !== 32'h1000 + 32'(11 + i)) begin errors++; $display("FAIL full_order %0d: got rd=%0d data=%h expected rd=%0d data=%h", i, got_rd[i], got_data[i], 11 + i, 32'h1000 + 32'(11 + i)); end
        end
        checks++; if (ld_count !== 3'd0) begin errors++; $display("FAIL full_drained: got %0d expected 0", ld_count); end
        idle_inputs();
        tick();
        $display("full: %0d loads written in acceptance order", got_rd.size());
    endtask

    task automatic test_rd0();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
        ld_valid  = 1'b1; ld_rd  = 5'd0; ld_data  = 32'hEEEE;
        settle();
        checks++; if (alu_ready !== 1'b1 || ld_ready !== 1'b1) begin errors++; $display("FAIL rd0_ready: got alu=%b ld=%b expected 1/1", alu_ready, ld_ready); end
        tick();
        alu_valid = 1'b0;
        for (int c = 1; c < 4; c++) begin
            if (c > 1) tick();
            ld_valid = (c == 1);
            settle();
            checks++; if (reg_write !== 1'b0 || ld_count !== 3'd0) begin errors++; $display("FAIL rd0 c%0d: got we=%b count=%0d expected 0/0", c, reg_write, ld_count); end
        end
        idle_inputs();
        tick();
        $display("rd0: alu and load rd=0 consumed without write");
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 3; c++) begin
            if (c > 0) tick();
            alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 32'h2121;
            ld_valid  = 1'b1; ld_rd  = 5'(c + 1); ld_data = 32'h3000 + 32'(c);
            settle();
        end
        tick();
        ld_valid = 1'b0;
        settle();
        checks++; if (ld_count !== 3'd3 || reg_write !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got count=%0d we=%b expected 3/1", ld_count, reg_write); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({reg_write, write_rd, write_data} !== 38'd0) begin errors++; $display("FAIL rstmid_outputs: got we=%b rd=%0d data=%h expected all 0", reg_write, write_rd, write_data); end
        checks++; if (ld_count !== 3'd0 || ld_ready !== 1'b1 || alu_ready !== 1'b1) begin errors++; $display("FAIL rstmid_state: got count=%0d ld_ready=%b alu_ready=%b expected 0/1/1", ld_count, ld_ready, alu_ready); end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++; if (reg_write !== 1'b0 || ld_count !== 3'd0) begin errors++; $display("FAIL rstmid_after c%0d: got we=%b rd=%0d count=%0d expected 0/0/0", c, reg_write, write_rd, ld_count); end
        end
        $display("reset_mid: buffered loads discarded");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_starvation();
        test_full();
        test_rd0();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
